fpnew_opgroup_ordered_arbiter: RTL and testbench
================================================

Name: fpnew_opgroup_ordered_arbiter

Overview:
- Generalised dispatch/retire arbiter that sits between an opgroup's operation issue and its NumIn parallel/merged format slices.
- Steers each dispatched operation to one slice and tracks every in-flight operation.
- Retires slice results through a registered output stage.
- Selectable mode: strict program-order retirement across slices of unequal latency, or round-robin retirement with an outstanding-operation limit.

Parameters:
- NumIn, 5: number of slices (channels).
- DataWidth, 64: packed result+status+ext_bit+tag width per slice.
- Depth, 8: maximum outstanding operations; order FIFO depth. Power of two, at least 2.
- InOrder, 1: 1 = retire in dispatch order; 0 = round-robin retirement.
- IdxWidth, max(1,$clog2(NumIn)): derived; slice index width.
- CntWidth, $clog2(Depth+1): derived; outstanding counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  synchronous flush of all tracking state
- dispatch_valid_i  in  1  operation offered
- dispatch_sel_i  in  IdxWidth  target slice of the offered operation
- dispatch_ready_o  out  1  operation accepted this cycle when high with valid
- slc_in_valid_o  out  NumIn  per-slice input valid
- slc_in_ready_i  in  NumIn  per-slice input ready
- slc_out_valid_i  in  NumIn  per-slice result valid
- slc_out_ready_o  out  NumIn  per-slice result ready
- slc_out_data_i  in  NumIn*DataWidth  per-slice result
- out_valid_o  out  1  registered result valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  DataWidth  registered result
- out_idx_o  out  IdxWidth  slice that produced out_data_o
- outstanding_o  out  CntWidth  operations dispatched but not yet retired into the output register
- full_o  out  1  outstanding_o == Depth
- busy_o  out  1  (outstanding_o != 0) or out_valid_o

Behaviour:
- Reset (rst_i high, async): out_valid_o=0, out_data_o=0, out_idx_o=0, outstanding=0, FIFO empty, rr pointer=0, full_o=0, busy_o=0. All comb outputs are 0 while their inputs are idle.
- Dispatch:
  - dispatch_ready_o = slc_in_ready_i[dispatch_sel_i] & !full_o.
  - slc_in_valid_o[k] = dispatch_valid_i & !full_o & (dispatch_sel_i==k).
  - A dispatch fires on valid & ready. In InOrder=1 it pushes dispatch_sel_i to the order FIFO.
  - full_o uses the registered count; a retire in the same cycle does not free a slot until the next cycle.
  - dispatch_sel_i >= NumIn: never ready, no slc_in_valid_o asserted.
- Output stage: can_load = !out_valid_o | out_ready_i.
- InOrder=1:
  - slc_out_ready_o[head] = !fifo_empty & can_load; all other bits are 0.
  - Retire fires when slc_out_valid_i[head] & ready: pop FIFO, load out_data_o/out_idx_o, set out_valid_o.
  - Non-head slices are back-pressured even if valid.
- InOrder=0:
  - Round-robin among slc_out_valid_i, starting at rr pointer.
  - The granted bit of slc_out_ready_o = can_load & (outstanding != 0).
  - On retire, rr pointer = granted+1, wrapping at NumIn to 0. FIFO logic is not instantiated.
- Latency: a result is on out_valid_o one cycle after the slice handshake. Back-to-back retires give full throughput when out_ready_i is held high.
- outstanding_o: +1 on dispatch, -1 on retire, unchanged when both or neither occur. Never exceeds Depth and never underflows; retire is gated at 0.
- out_valid_o clears on out_ready_i when no retire occurs in the same cycle. If both happen, the new data replaces the old.
- Flush (flush_i high at a clock edge):
  - Count=0, FIFO pointers reset, out_valid_o=0, rr pointer=0.
  - dispatch_ready_o and all slc_out_ready_o are forced 0 during the flush cycle.
  - Slices are flushed by their own flush_i.
- FIFO pointers carry an extra wrap bit. Full/empty are derived from pointer equality plus the wrap bit, and must agree with the count.
- Reset asserted mid-transfer: all state clears immediately; no handshake completes in that cycle.

Decomposition:
- Shared package fpnew_pkg gains:
  - arb_mode_e (IN_ORDER, ROUND_ROBIN), mapped from InOrder;
  - function idx_width(NumIn).
- One sub-module: fpnew_order_fifo (Depth x IdxWidth, push/pop/flush, full/empty, async active-high reset), instantiated only when InOrder=1.
- Round-robin select and the output register stay inline.

Test Plan:
- InOrder=1, NumIn=2, Depth=4; dispatch to slices 1,0,1. Slice 0 returns its result first (data 0xA0), then slice 1 returns 0xB1 and 0xB2 → out_data_o order 0xB1,0xA0,0xB2 with out_idx_o 1,0,1. Slice 0 is held not-ready until 0xB1 is retired.
- Depth=4, 4 dispatches with no results → full_o=1, dispatch_ready_o=0, outstanding_o=4. Next cycle one retire with a dispatch offered → dispatch still refused; the following cycle dispatch is accepted and the count returns to 4.
- InOrder=0, NumIn=3, all three slices valid continuously, out_ready_i=1 → grants 0,1,2,0,… one per cycle, outstanding_o decrements by 1 each cycle.
- out_ready_i=0 with out_valid_o=1 → slc_out_ready_o is all 0 and out_data_o is stable. Raising out_ready_i while a slice is valid → new data is loaded in the same edge and out_valid_o stays 1.
- 3 outstanding, out_valid_o=1, assert flush_i for one cycle → next cycle outstanding_o=0, out_valid_o=0, busy_o=0. A fresh dispatch to slice 2 retires normally.
- Assert rst_i asynchronously between edges with full_o=1 → all outputs drop to reset values before the next clk_i edge.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared opgroup definitions: the retirement mode and the slice-index width helper.
package fpnew_pkg;

  typedef enum logic {
    IN_ORDER    = 1'b0,
    ROUND_ROBIN = 1'b1
  } arb_mode_e;

  function automatic int idx_width(input int num_in);
    return (num_in > 1) ? $clog2(num_in) : 1;
  endfunction

endpackage

// File: rtl/fpnew_opgroup_ordered_arbiter_if.sv
// Dispatch, slice and retire handshake bundle for the opgroup arbiter.
interface fpnew_opgroup_ordered_arbiter_if #(
  parameter int NumIn     = 5,
  parameter int DataWidth = 64,
  parameter int Depth     = 8,
  parameter int IdxWidth  = fpnew_pkg::idx_width(NumIn),
  parameter int CntWidth  = $clog2(Depth + 1)
);
  logic                       flush_i;
  logic                       dispatch_valid_i;
  logic [IdxWidth-1:0]        dispatch_sel_i;
  logic                       dispatch_ready_o;
  logic [NumIn-1:0]           slc_in_valid_o;
  logic [NumIn-1:0]           slc_in_ready_i;
  logic [NumIn-1:0]           slc_out_valid_i;
  logic [NumIn-1:0]           slc_out_ready_o;
  logic [NumIn*DataWidth-1:0] slc_out_data_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [DataWidth-1:0]       out_data_o;
  logic [IdxWidth-1:0]        out_idx_o;
  logic [CntWidth-1:0]        outstanding_o;
  logic                       full_o;
  logic                       busy_o;

  modport slave (
    input  flush_i, dispatch_valid_i, dispatch_sel_i, slc_in_ready_i,
           slc_out_valid_i, slc_out_data_i, out_ready_i,
    output dispatch_ready_o, slc_in_valid_o, slc_out_ready_o, out_valid_o,
           out_data_o, out_idx_o, outstanding_o, full_o, busy_o
  );

  modport master (
    output flush_i, dispatch_valid_i, dispatch_sel_i, slc_in_ready_i,
           slc_out_valid_i, slc_out_data_i, out_ready_i,
    input  dispatch_ready_o, slc_in_valid_o, slc_out_ready_o, out_valid_o,
           out_data_o, out_idx_o, outstanding_o, full_o, busy_o
  );
endinterface

// File: rtl/fpnew_order_fifo.sv
// Dispatch-order FIFO of slice indices; pointers carry a wrap bit for full/empty.
module fpnew_order_fifo #(
  parameter int Depth = 8,
  parameter int Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW:0]    r_wr;
  logic [PtrW:0]    r_rd;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (r_wr == r_rd);
  assign full_o  = (r_wr[PtrW] != r_rd[PtrW]) && (r_wr[PtrW-1:0] == r_rd[PtrW-1:0]);
  assign data_o  = r_mem[r_rd[PtrW-1:0]];
  assign w_push  = push_i & !full_o;
  assign w_pop   = pop_i & !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (flush_i) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr[PtrW-1:0]] <= data_i;
  end
endmodule

// File: rtl/fpnew_opgroup_ordered_arbiter.sv
// Steers operations to slices, counts in-flight work and retires results in
// dispatch order or round-robin through a single output register.
module fpnew_opgroup_ordered_arbiter
  import fpnew_pkg::*;
#(
  parameter int NumIn     = 5,
  parameter int DataWidth = 64,
  parameter int Depth     = 8,
  parameter int InOrder   = 1
) (
  input logic clk_i,
  input logic rst_i,
  fpnew_opgroup_ordered_arbiter_if.slave bus
);
  localparam int        IdxWidth = idx_width(NumIn);
  localparam int        CntWidth = $clog2(Depth + 1);
  localparam arb_mode_e Mode     = (InOrder != 0) ? IN_ORDER : ROUND_ROBIN;

  logic [CntWidth-1:0]  r_cnt;
  logic                 r_out_valid;
  logic [DataWidth-1:0] r_out_data;
  logic [IdxWidth-1:0]  r_out_idx;

  logic                 w_full, w_block, w_sel_ready, w_dispatch;
  logic                 w_can_load, w_ok, w_retire;
  logic [NumIn-1:0]     w_slc_in_valid, w_slc_out_ready;
  logic [IdxWidth-1:0]  w_sel_idx;
  logic [DataWidth-1:0] w_sel_data;

  assign w_full     = (r_cnt == CntWidth'(Depth));
  assign w_can_load = !r_out_valid | bus.out_ready_i;
  // Nothing may handshake on the retire side during a flush or while reset is held.
  assign w_ok       = w_can_load & !bus.flush_i & !rst_i;

  always_comb begin
    w_sel_ready    = 1'b0;
    w_slc_in_valid = '0;
    for (int k = 0; k < NumIn; k++) begin
      if (bus.dispatch_sel_i == IdxWidth'(k)) begin
        w_sel_ready       = bus.slc_in_ready_i[k];
        w_slc_in_valid[k] = bus.dispatch_valid_i & !w_block & !rst_i;
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NumIn; k++) begin
      if (w_sel_idx == IdxWidth'(k)) w_sel_data = bus.slc_out_data_i[k*DataWidth +: DataWidth];
    end
  end

  assign bus.dispatch_ready_o = w_sel_ready & !w_block & !bus.flush_i & !rst_i;
  assign w_dispatch           = bus.dispatch_valid_i & bus.dispatch_ready_o;
  assign bus.slc_in_valid_o   = w_slc_in_valid;
  assign bus.slc_out_ready_o  = w_slc_out_ready;

  generate
    if (Mode == IN_ORDER) begin : g_in_order
      logic [IdxWidth-1:0] w_head;
      logic                w_empty, w_fifo_full, w_head_valid;

      fpnew_order_fifo #(.Depth(Depth), .Width(IdxWidth)) u_order_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (bus.flush_i),
        .push_i  (w_dispatch),
        .data_i  (bus.dispatch_sel_i),
        .pop_i   (w_retire),
        .data_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_empty)
      );

      // Count and FIFO occupancy track each other; either one blocks dispatch.
      assign w_block = w_full | w_fifo_full;

      always_comb begin
        w_slc_out_ready = '0;
        w_head_valid    = 1'b0;
        for (int k = 0; k < NumIn; k++) begin
          if (w_head == IdxWidth'(k)) begin
            w_slc_out_ready[k] = !w_empty & w_ok;
            w_head_valid       = bus.slc_out_valid_i[k];
          end
        end
      end

      assign w_retire  = !w_empty & w_ok & w_head_valid;
      assign w_sel_idx = w_head;
    end else begin : g_round_robin
      logic [IdxWidth-1:0] r_rr;
      logic [IdxWidth-1:0] w_grant;
      logic                w_found, w_rr_ok;

      assign w_block = w_full;
      assign w_rr_ok = w_ok & (r_cnt != '0);

      always_comb begin : rr_pick
        int j;
        j       = 0;
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NumIn; i++) begin
          j = (int'(r_rr) + i) % NumIn;
          if (!w_found && bus.slc_out_valid_i[j]) begin
            w_found = 1'b1;
            w_grant = IdxWidth'(j);
          end
        end
      end

      always_comb begin
        w_slc_out_ready = '0;
        for (int k = 0; k < NumIn; k++) begin
          if (w_grant == IdxWidth'(k)) w_slc_out_ready[k] = w_found & w_rr_ok;
        end
      end

      assign w_retire  = w_found & w_rr_ok;
      assign w_sel_idx = w_grant;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_rr <= '0;
        end else if (bus.flush_i) begin
          r_rr <= '0;
        end else if (w_retire) begin
          r_rr <= (w_grant == IdxWidth'(NumIn - 1)) ? '0 : w_grant + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
    end else if (bus.flush_i) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_dispatch && !w_retire)      r_cnt <= r_cnt + CntWidth'(1);
      else if (!w_dispatch && w_retire) r_cnt <= r_cnt - CntWidth'(1);
      if (w_retire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_idx   <= w_sel_idx;
      end else if (bus.out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid_o   = r_out_valid;
  assign bus.out_data_o    = r_out_data;
  assign bus.out_idx_o     = r_out_idx;
  assign bus.outstanding_o = r_cnt;
  assign bus.full_o        = w_full;
  assign bus.busy_o        = (r_cnt != '0) | r_out_valid;
endmodule

// File: tb/tb_fpnew_opgroup_ordered_arbiter.sv
// Directed bench: one in-order and one round-robin arbiter (3 slices, depth 4).
module tb_fpnew_opgroup_ordered_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  fpnew_opgroup_ordered_arbiter_if #(.NumIn(3), .DataWidth(8), .Depth(4)) ifo ();
  fpnew_opgroup_ordered_arbiter_if #(.NumIn(3), .DataWidth(8), .Depth(4)) ifr ();

  fpnew_opgroup_ordered_arbiter #(.NumIn(3), .DataWidth(8), .Depth(4), .InOrder(1)) u_ord (
    .clk_i (clk_i), .rst_i (rst_i), .bus (ifo)
  );
  fpnew_opgroup_ordered_arbiter #(.NumIn(3), .DataWidth(8), .Depth(4), .InOrder(0)) u_rr (
    .clk_i (clk_i), .rst_i (rst_i), .bus (ifr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    ifo.flush_i = 0; ifo.dispatch_valid_i = 0; ifo.dispatch_sel_i = 0; ifo.slc_in_ready_i = 0;
    ifo.slc_out_valid_i = 0; ifo.slc_out_data_i = 0; ifo.out_ready_i = 0;
    ifr.flush_i = 0; ifr.dispatch_valid_i = 0; ifr.dispatch_sel_i = 0; ifr.slc_in_ready_i = 0;
    ifr.slc_out_valid_i = 0; ifr.slc_out_data_i = 0; ifr.out_ready_i = 0;

    #3;
    chk("rst_out_valid", ifo.out_valid_o, 0);
    chk("rst_outstanding", ifo.outstanding_o, 0);
    chk("rst_full", ifo.full_o, 0);
    chk("rst_busy", ifo.busy_o, 0);
    chk("rst_out_data", ifo.out_data_o, 0);
    chk("rst_rr_outstanding", ifr.outstanding_o, 0);
    #9 rst_i = 0;
    ifo.slc_in_ready_i = 3'b111; ifo.out_ready_i = 1;
    ifr.slc_in_ready_i = 3'b111; ifr.out_ready_i = 1;
    tick();

    // ---- in-order retirement across unequal latencies: dispatch 1,0,1
    ifo.dispatch_valid_i = 1; ifo.dispatch_sel_i = 1; #1;
    chk("disp_ready", ifo.dispatch_ready_o, 1);
    chk("slc_in_valid", ifo.slc_in_valid_o, 3'b010);
    tick();
    ifo.dispatch_sel_i = 0; tick();
    ifo.dispatch_sel_i = 1; tick();
    ifo.dispatch_valid_i = 0;
    chk("ord_cnt3", ifo.outstanding_o, 3);
    ifo.slc_out_valid_i = 3'b001; ifo.slc_out_data_i = {8'h00, 8'h00, 8'hA0}; #1;
    chk("ord_head_only_ready", ifo.slc_out_ready_o, 3'b010);
    tick();
    chk("ord_nonhead_held", ifo.out_valid_o, 0);
    ifo.slc_out_valid_i = 3'b011; ifo.slc_out_data_i = {8'h00, 8'hB1, 8'hA0}; #1;
    chk("ord_ready_b1", ifo.slc_out_ready_o, 3'b010);
    tick();
    chk("ord_data_b1", ifo.out_data_o, 8'hB1);
    chk("ord_idx_b1", ifo.out_idx_o, 1);
    chk("ord_valid_b1", ifo.out_valid_o, 1);
    chk("ord_cnt2", ifo.outstanding_o, 2);
    ifo.slc_out_valid_i = 3'b001; #1;
    chk("ord_ready_a0", ifo.slc_out_ready_o, 3'b001);
    tick();
    chk("ord_data_a0", ifo.out_data_o, 8'hA0);
    chk("ord_idx_a0", ifo.out_idx_o, 0);
    ifo.slc_out_valid_i = 3'b010; ifo.slc_out_data_i = {8'h00, 8'hB2, 8'h00}; tick();
    chk("ord_data_b2", ifo.out_data_o, 8'hB2);
    chk("ord_idx_b2", ifo.out_idx_o, 1);
    chk("ord_cnt0", ifo.outstanding_o, 0);
    ifo.slc_out_valid_i = 0; tick();
    chk("ord_drain_valid", ifo.out_valid_o, 0);
    chk("ord_drain_busy", ifo.busy_o, 0);

    // ---- out-of-range select is never accepted
    ifo.dispatch_valid_i = 1; ifo.dispatch_sel_i = 3; #1;
    chk("oor_ready", ifo.dispatch_ready_o, 0);
    chk("oor_slc_valid", ifo.slc_in_valid_o, 0);

    // ---- fill to Depth, then retire and dispatch in the same cycle
    ifo.dispatch_sel_i = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("full_flag", ifo.full_o, 1);
    chk("full_cnt", ifo.outstanding_o, 4);
    chk("full_disp_ready", ifo.dispatch_ready_o, 0);
    chk("full_slc_valid", ifo.slc_in_valid_o, 0);
    ifo.slc_out_valid_i = 3'b001; ifo.slc_out_data_i = {8'h00, 8'h00, 8'h11}; #1;
    chk("full_retire_refuse", ifo.dispatch_ready_o, 0);
    tick();
    chk("full_after_retire_cnt", ifo.outstanding_o, 3);
    chk("full_after_retire_data", ifo.out_data_o, 8'h11);
    ifo.slc_out_valid_i = 0; #1;
    chk("full_accept_next", ifo.dispatch_ready_o, 1);
    tick();
    ifo.dispatch_valid_i = 0;
    chk("full_again_cnt", ifo.outstanding_o, 4);
    chk("full_again_flag", ifo.full_o, 1);

    // ---- output back-pressure then same-edge replacement
    ifo.out_ready_i = 0; ifo.slc_out_valid_i = 3'b001; ifo.slc_out_data_i = {8'h00, 8'h00, 8'h22}; tick();
    chk("bp_load22", ifo.out_data_o, 8'h22);
    ifo.slc_out_data_i = {8'h00, 8'h00, 8'h33}; #1;
    chk("bp_ready_zero", ifo.slc_out_ready_o, 3'b000);
    tick();
    chk("bp_data_stable", ifo.out_data_o, 8'h22);
    chk("bp_valid_held", ifo.out_valid_o, 1);
    chk("bp_cnt3", ifo.outstanding_o, 3);
    ifo.out_ready_i = 1; #1;
    chk("bp_release_ready", ifo.slc_out_ready_o, 3'b001);
    tick();
    chk("bp_replace_data", ifo.out_data_o, 8'h33);
    chk("bp_replace_valid", ifo.out_valid_o, 1);
    chk("bp_cnt2", ifo.outstanding_o, 2);

    // ---- flush with 3 outstanding and a held result
    ifo.slc_out_valid_i = 0; ifo.out_ready_i = 0;
    ifo.dispatch_valid_i = 1; ifo.dispatch_sel_i = 0; tick();
    chk("pre_flush_cnt", ifo.outstanding_o, 3);
    chk("pre_flush_valid", ifo.out_valid_o, 1);
    ifo.flush_i = 1; ifo.dispatch_sel_i = 2; #1;
    chk("flush_disp_ready", ifo.dispatch_ready_o, 0);
    tick();
    ifo.flush_i = 0; ifo.dispatch_valid_i = 0;
    chk("flush_cnt", ifo.outstanding_o, 0);
    chk("flush_valid", ifo.out_valid_o, 0);
    chk("flush_busy", ifo.busy_o, 0);
    ifo.dispatch_valid_i = 1; ifo.dispatch_sel_i = 2; tick();
    ifo.dispatch_valid_i = 0;
    chk("post_flush_cnt", ifo.outstanding_o, 1);
    ifo.out_ready_i = 1; ifo.slc_out_valid_i = 3'b100; ifo.slc_out_data_i = {8'hC2, 8'h00, 8'h00}; #1;
    chk("post_flush_ready", ifo.slc_out_ready_o, 3'b100);
    tick();
    chk("post_flush_data", ifo.out_data_o, 8'hC2);
    chk("post_flush_idx", ifo.out_idx_o, 2);
    chk("post_flush_cnt0", ifo.outstanding_o, 0);
    ifo.slc_out_valid_i = 0; tick();

    // ---- asynchronous reset while full with a held result
    ifo.dispatch_valid_i = 1; ifo.dispatch_sel_i = 1;
    for (int i = 0; i < 4; i++) tick();
    ifo.out_ready_i = 0; ifo.slc_out_valid_i = 3'b010; ifo.slc_out_data_i = {8'h00, 8'h44, 8'h00}; tick();
    ifo.slc_out_valid_i = 0; tick();
    chk("arst_pre_full", ifo.full_o, 1);
    chk("arst_pre_valid", ifo.out_valid_o, 1);
    #2 rst_i = 1; #1;
    chk("arst_full", ifo.full_o, 0);
    chk("arst_cnt", ifo.outstanding_o, 0);
    chk("arst_valid", ifo.out_valid_o, 0);
    chk("arst_data", ifo.out_data_o, 0);
    chk("arst_busy", ifo.busy_o, 0);
    chk("arst_disp_ready", ifo.dispatch_ready_o, 0);
    ifo.dispatch_valid_i = 0; ifo.out_ready_i = 1;
    #2 rst_i = 0;
    tick();

    // ---- round-robin retirement, all three slices valid
    ifr.dispatch_valid_i = 1; ifr.dispatch_sel_i = 0;
    for (int i = 0; i < 4; i++) tick();
    ifr.dispatch_valid_i = 0;
    chk("rr_full", ifr.full_o, 1);
    ifr.slc_out_valid_i = 3'b111; ifr.slc_out_data_i = {8'h32, 8'h21, 8'h10}; #1;
    chk("rr_grant0_ready", ifr.slc_out_ready_o, 3'b001);
    tick();
    chk("rr_idx0", ifr.out_idx_o, 0);
    chk("rr_cnt3", ifr.outstanding_o, 3);
    chk("rr_grant1_ready", ifr.slc_out_ready_o, 3'b010);
    tick();
    chk("rr_idx1", ifr.out_idx_o, 1);
    chk("rr_data1", ifr.out_data_o, 8'h21);
    chk("rr_cnt2", ifr.outstanding_o, 2);
    tick();
    chk("rr_idx2", ifr.out_idx_o, 2);
    chk("rr_cnt1", ifr.outstanding_o, 1);
    tick();
    chk("rr_wrap_idx0", ifr.out_idx_o, 0);
    chk("rr_cnt0", ifr.outstanding_o, 0);
    chk("rr_zero_gate", ifr.slc_out_ready_o, 3'b000);
    ifr.slc_out_valid_i = 0; tick();
    chk("rr_drain_valid", ifr.out_valid_o, 0);
    ifr.dispatch_valid_i = 1; ifr.dispatch_sel_i = 2; tick();
    ifr.dispatch_valid_i = 0;
    ifr.slc_out_valid_i = 3'b001; #1;
    chk("rr_search_wrap", ifr.slc_out_ready_o, 3'b001);
    tick();
    chk("rr_search_idx", ifr.out_idx_o, 0);
    chk("rr_search_data", ifr.out_data_o, 8'h10);
    ifr.slc_out_valid_i = 0; tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
